nios2_qsys_mulx_cell: RTL

NIOS2_QSYS_MULX_CELL -- requirements
Module: nios2_qsys_mulx_cell

---
 rtl/nios2_qsys_mulx_cell_pkg.sv | 23 ++
 rtl/nios2_qsys_mulx_cell_stage.sv | 52 +++++
 rtl/nios2_qsys_mulx_cell.sv | 82 ++++++++
 3 files changed

// File: rtl/nios2_qsys_mulx_cell_pkg.sv
// Shared mode encoding and pipeline-depth limits for the multiply cell.
// Operand signedness helpers keep the extension rule in one place.
package nios2_qsys_mulx_cell_pkg;

    typedef enum logic [1:0] {
        MODE_MUL    = 2'b00,
        MODE_MULXUU = 2'b01,
        MODE_MULXSU = 2'b10,
        MODE_MULXSS = 2'b11
    } mode_e;

    localparam int PIPE_STAGES_MIN = 1;
    localparam int PIPE_STAGES_MAX = 4;

    function automatic logic src1_is_signed(input logic [1:0] mode);
        return (mode == MODE_MULXSU) || (mode == MODE_MULXSS);
    endfunction

    function automatic logic src2_is_signed(input logic [1:0] mode);
        return (mode == MODE_MULXSS);
    endfunction

endpackage

// File: rtl/nios2_qsys_mulx_cell_stage.sv
// One pipeline slice: valid, tag, mode and product data, advancing only when en=1.
// CLR_DATA=1 resets the payload too (used for the output slice so result/tag_out clear).
module nios2_qsys_mulx_stage #(
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 5,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              vld_d,
    input  logic [TAG_W-1:0]  tag_d,
    input  logic [1:0]        mode_d,
    input  logic [DATA_W-1:0] dat_d,
    output logic              vld_q,
    output logic [TAG_W-1:0]  tag_q,
    output logic [1:0]        mode_q,
    output logic [DATA_W-1:0] dat_q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
        end else if (en) begin
            vld_q <= vld_d;
        end
    end

    if (CLR_DATA) begin : g_clr
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                tag_q  <= '0;
                mode_q <= '0;
                dat_q  <= '0;
            end else if (en) begin
                tag_q  <= tag_d;
                mode_q <= mode_d;
                dat_q  <= dat_d;
            end
        end
    end else begin : g_noclr
        // No reset on internal payload so the multiplier can retime into these flops.
        always_ff @(posedge clk) begin
            if (en) begin
                tag_q  <= tag_d;
                mode_q <= mode_d;
                dat_q  <= dat_d;
            end
        end
    end

endmodule

// File: rtl/nios2_qsys_mulx_cell.sv
// Pipelined Nios II MUL/MULX unit; result PIPE_STAGES cycles after accept.
// Whole pipe freezes while an output is held (in_ready = ~(out_valid & ~out_ready)).
module nios2_qsys_mulx_cell
    import nios2_qsys_mulx_cell_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        mode,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  tag_out
);

    localparam int NS = (PIPE_STAGES < PIPE_STAGES_MIN) ? PIPE_STAGES_MIN :
                        (PIPE_STAGES > PIPE_STAGES_MAX) ? PIPE_STAGES_MAX : PIPE_STAGES;
    localparam int PW = 2 * DATA_W;

    logic              stall;
    logic [NS:0]       vld;
    logic [TAG_W-1:0]  tag   [NS+1];
    logic [1:0]        mode_p[NS+1];
    logic [PW-1:0]     dat   [NS+1];

    logic [DATA_W:0]   a_ext;
    logic [DATA_W:0]   b_ext;
    logic [PW-1:0]     a_wide;
    logic [PW-1:0]     b_wide;
    logic [PW-1:0]     prod;

    assign stall    = vld[NS] & ~out_ready;
    assign in_ready = ~stall;

    // Two's-complement operands widened to 2*DATA_W: the low 2*DATA_W bits of an
    // unsigned multiply then equal the exact signed/unsigned product.
    always_comb begin
        a_ext  = {src1_is_signed(mode) & src1[DATA_W-1], src1};
        b_ext  = {src2_is_signed(mode) & src2[DATA_W-1], src2};
        a_wide = {{(DATA_W-1){a_ext[DATA_W]}}, a_ext};
        b_wide = {{(DATA_W-1){b_ext[DATA_W]}}, b_ext};
        prod   = a_wide * b_wide;
    end

    assign vld[0]    = in_valid;
    assign tag[0]    = tag_in;
    assign mode_p[0] = mode;
    assign dat[0]    = prod;

    for (genvar i = 0; i < NS; i++) begin : g_stage
        nios2_qsys_mulx_stage #(
            .DATA_W   (PW),
            .TAG_W    (TAG_W),
            .CLR_DATA (i == NS - 1)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (~stall),
            .vld_d   (vld[i]),
            .tag_d   (tag[i]),
            .mode_d  (mode_p[i]),
            .dat_d   (dat[i]),
            .vld_q   (vld[i+1]),
            .tag_q   (tag[i+1]),
            .mode_q  (mode_p[i+1]),
            .dat_q   (dat[i+1])
        );
    end

    assign out_valid = vld[NS];
    assign tag_out   = tag[NS];
    assign result    = (mode_p[NS] == MODE_MUL) ? dat[NS][DATA_W-1:0] : dat[NS][PW-1:DATA_W];

endmodule
